// File: rtl/datapath_run_ctrl.sv
// datapath_run_ctrl: reset/run sequencer for DataPath plus a
// first-word-fall-through trace FIFO of register write-backs.
module datapath_run_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [CNT_WIDTH-1:0]    RunCycles,
  output logic                    CoreReset,
  input  logic [DATA_WIDTH-1:0]   WriteData,
  input  logic                    WriteValid,
  output logic [DATA_WIDTH-1:0]   TraceData,
  output logic                    TraceValid,
  input  logic                    TraceReady,
  output logic [$clog2(DEPTH):0]  Count,
  output logic                    Overflow,
  output logic                    Busy,
  output logic                    Done
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  localparam logic [HW-1:0] L_HOLD = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [HW-1:0]         r_hold;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  r_len;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr;
  logic [AW-1:0]         r_rd;
  logic [AW:0]           r_count;
  logic                  r_ovf;

  logic w_start;
  logic w_run;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_start = Start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_run   = (r_state == S_RUN);
  assign w_full  = (r_count == L_FULL);
  assign w_pop   = (r_count != '0) & TraceReady;
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign w_push  = w_run & WriteValid & (~w_full | w_pop);
  assign w_drop  = w_run & WriteValid & w_full & ~w_pop;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_hold    <= '0;
      r_cnt     <= '0;
      r_len     <= CNT_WIDTH'(1);
      CoreReset <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            r_state <= S_HOLD;
            r_hold  <= '0;
            r_cnt   <= '0;
            r_len   <= (RunCycles == '0) ? CNT_WIDTH'(1) : RunCycles;
            Busy    <= 1'b1;
            Done    <= 1'b0;
          end
        end
        S_HOLD: begin
          if (r_hold == L_HOLD) begin
            r_state   <= S_RUN;
            CoreReset <= 1'b0;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
          if (r_cnt == r_len - CNT_WIDTH'(1)) begin
            r_state   <= S_DONE;
            CoreReset <= 1'b1;
            Busy      <= 1'b0;
            Done      <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          CoreReset <= 1'b1;
          Busy      <= 1'b0;
          Done      <= 1'b0;
        end
      endcase
    end
  end

  // an accepted Start flushes the trace, winning over any pop
  always_ff @(posedge Clk) begin
    if (!Reset || w_start) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, w_push}
                         - {{AW{1'b0}}, w_pop};
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wr] <= WriteData;
  end

  assign TraceData  = r_mem[r_rd];
  assign TraceValid = (r_count != '0);
  assign Count      = r_count;
  assign Overflow   = r_ovf;

endmodule

// File: tb/tb_datapath_run_ctrl.sv
// Directed bench for datapath_run_ctrl: run window timing,
// trace capture, overflow, concurrent pop, start and reset handling.
module tb_datapath_run_ctrl;

  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int H = 2;
  localparam int CW = 16;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic [CW-1:0] RunCycles;
  logic          CoreReset;
  logic [DW-1:0] WriteData;
  logic          WriteValid;
  logic [DW-1:0] TraceData;
  logic          TraceValid;
  logic          TraceReady;
  logic [4:0]    Count;
  logic          Overflow;
  logic          Busy;
  logic          Done;

  int n_run = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  datapath_run_ctrl #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .HOLD_CYCLES(H),
    .CNT_WIDTH  (CW)
  ) u_dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .RunCycles (RunCycles),
    .CoreReset (CoreReset),
    .WriteData (WriteData),
    .WriteValid(WriteValid),
    .TraceData (TraceData),
    .TraceValid(TraceValid),
    .TraceReady(TraceReady),
    .Count     (Count),
    .Overflow  (Overflow),
    .Busy      (Busy),
    .Done      (Done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Start accepted at edge t; data for edge t+i is base+i-4, so
  // the first RUN-state capture (edge t+H+2) carries base.
  task automatic run(input int rc, input int base, input int rdy_from,
                     input int sp);
    int len;
    len = (rc == 0) ? 1 : rc;
    Start = 1'b1;
    RunCycles = rc[CW-1:0];
    tick();
    Start = 1'b0;
    chk("start_busy", Busy, 1'b1);
    chk("start_done", Done, 1'b0);
    chk("start_count", Count, 0);
    chk("start_ovf", Overflow, 1'b0);
    for (int i = 1; i <= H + 1 + len; i++) begin
      WriteData = base + i - (H + 2);
      TraceReady = ((i - (H + 2)) >= rdy_from);
      Start = (i == sp);
      tick();
      chk($sformatf("corerst_%0d", i), CoreReset,
          (i >= H + 1 && i <= H + len) ? 1'b0 : 1'b1);
      chk($sformatf("done_%0d", i), Done, (i == H + 1 + len));
    end
    Start = 1'b0;
    TraceReady = 1'b0;
    chk("end_busy", Busy, 1'b0);
  endtask

  task automatic drain(input int n, input int base);
    TraceReady = 1'b1;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("drain_valid_%0d", k), TraceValid, 1'b1);
      chk($sformatf("drain_data_%0d", k), TraceData, base + k);
      tick();
    end
    TraceReady = 1'b0;
  endtask

  initial begin
    Reset = 1'b0;
    Start = 1'b0;
    RunCycles = '0;
    WriteData = '0;
    WriteValid = 1'b1;
    TraceReady = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    chk("rst_corerst", CoreReset, 1'b1);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_valid", TraceValid, 1'b0);
    chk("rst_count", Count, 0);
    chk("rst_ovf", Overflow, 1'b0);

    // basic run, 5 captures
    run(5, 32'h10, 99, -1);
    chk("basic_count", Count, 5);
    chk("basic_ovf", Overflow, 1'b0);
    drain(5, 32'h10);
    chk("basic_empty", TraceValid, 1'b0);

    // overflow: 20 pushes into 16 entries
    run(20, 32'h100, 99, -1);
    chk("ovf_count", Count, 16);
    chk("ovf_flag", Overflow, 1'b1);
    drain(16, 32'h100);
    chk("ovf_empty", TraceValid, 1'b0);
    chk("ovf_sticky", Overflow, 1'b1);

    // full with concurrent pop: entries 0..7 leave, 8..23 remain
    run(24, 32'h200, 16, -1);
    chk("cpop_count", Count, 16);
    chk("cpop_ovf", Overflow, 1'b0);
    drain(4, 32'h208);
    chk("cpop_left", Count, 12);

    // Start in DONE clears a non-empty FIFO; Start pulses while busy ignored
    run(3, 32'h300, 99, 5);
    chk("ign_count", Count, 3);
    drain(3, 32'h300);

    // reset in the middle of a run
    Start = 1'b1;
    RunCycles = 16'd10;
    tick();
    Start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      WriteData = 32'h500 + i;
      tick();
    end
    chk("mid_count_pre", Count, 2);
    chk("mid_corerst_pre", CoreReset, 1'b0);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    chk("mid_corerst", CoreReset, 1'b1);
    chk("mid_busy", Busy, 1'b0);
    chk("mid_done", Done, 1'b0);
    chk("mid_count", Count, 0);
    chk("mid_valid", TraceValid, 1'b0);

    // RunCycles = 0 runs exactly one cycle
    run(0, 32'h600, 99, -1);
    chk("zero_count", Count, 1);
    drain(1, 32'h600);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_run_ctrl.md
# datapath_run_ctrl

Synthesizable run controller and write-back trace buffer for the single-cycle `DataPath`. It sequences the datapath's reset and run window. For a programmed number of cycles it captures every register write-back value into a parametrised FIFO, and the bench or a debug host drains that FIFO with a ready/valid handshake. It sits between the top level and `DataPath`: it drives the datapath's reset and taps its `WriteData` bus.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of captured write-back data.
- `DEPTH`, 16: trace FIFO entries; must be a power of two and at least 2.
- `HOLD_CYCLES`, 2: cycles the datapath is held in reset before each run; must be at least 1.
- `CNT_WIDTH`, 16: width of the run-cycle counter.

Ports:
- `Clk`, in, 1: single clock; all logic is rising-edge.
- `Reset`, in, 1: synchronous, active-low reset.
- `Start`, in, 1: run request, sampled every cycle; ignored while `Busy`=1.
- `RunCycles`, in, `CNT_WIDTH`: run length, latched on an accepted `Start`; a value of 0 is treated as 1.
- `CoreReset`, out, 1: active-high reset to `DataPath`.
- `WriteData`, in, `DATA_WIDTH`: datapath write-back value.
- `WriteValid`, in, 1: datapath register-write enable for the current cycle.
- `TraceData`, out, `DATA_WIDTH`: FIFO head, first-word fall-through.
- `TraceValid`, out, 1: FIFO is not empty.
- `TraceReady`, in, 1: consumer accepts the head entry.
- `Count`, out, log2(`DEPTH`)+1: current FIFO occupancy.
- `Overflow`, out, 1: sticky flag; set when a capture is dropped.
- `Busy`, out, 1: high in HOLD or RUN.
- `Done`, out, 1: high in DONE.

## Operation
- Reset is applied when `Reset`=0 at a rising edge. After reset:
  - State is IDLE.
  - `CoreReset`=1; `Busy`=0; `Done`=0.
  - `TraceValid`=0; `Count`=0; `Overflow`=0.
  - Run counter and FIFO pointers are 0.
- Reset asserted mid-run overrides everything. The FIFO contents are discarded.
- FSM states and transitions:
  - IDLE: `CoreReset`=1. `Start` moves to HOLD.
  - HOLD: `CoreReset`=1. After `HOLD_CYCLES` cycles, moves to RUN.
  - RUN: `CoreReset`=0. The counter increments each cycle. After the latched `RunCycles` cycles, moves to DONE.
  - DONE: `CoreReset`=1; `Done`=1. `Start` moves to HOLD.
- An accepted `Start` (in IDLE or DONE) also does the following in the same edge:
  - Clears the FIFO, `Count` and `Overflow`.
  - Clears the run counter.
  - Latches `RunCycles`.
  - The clear wins over a simultaneous pop.
- Capture rules:
  - Only in RUN: on `WriteValid`=1, `WriteData` is pushed.
  - `WriteValid` is ignored in all other states.
- Push when full:
  - Without a simultaneous pop: the data is dropped and `Overflow` is set to 1.
  - With a simultaneous pop (`TraceValid`&`TraceReady`): both happen and `Count` is unchanged.
- Pop rules:
  - A pop occurs on `TraceValid`&`TraceReady` and is legal in any state, including during RUN.
  - A pop when empty is a no-op.
- Push and pop on a non-full, non-empty FIFO leave `Count` unchanged.
- Pointers wrap modulo `DEPTH`. `Count` ranges 0..`DEPTH`.
- `TraceData` is unspecified while `TraceValid`=0.

## Timing
- Run window: let `Start` be accepted at edge t.
  - HOLD occupies cycles t+1 .. t+`HOLD_CYCLES`.
  - `CoreReset` falls at edge t+`HOLD_CYCLES`+1.
  - `CoreReset` stays 0 for exactly max(`RunCycles`,1) cycles.
  - `Done`=1 and `CoreReset`=1 from edge t+`HOLD_CYCLES`+max(`RunCycles`,1)+1.
- Capture latency:
  - `WriteValid` sampled at edge c is pushed at c.
  - `TraceValid`/`Count` reflect the push after edge c.
  - `TraceData` shows the entry in the same cycle if the FIFO was previously empty.
- Pop latency: the next head appears the cycle after the popping edge.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.

## Test plan
- Reset and idle: hold `Reset`=0 for 2 cycles, then release. Required: `CoreReset`=1, `Busy`=0, `Done`=0, `TraceValid`=0, `Count`=0, `Overflow`=0.
- Basic run: `HOLD_CYCLES`=2, `RunCycles`=5, `Start` at edge t, with `WriteValid`=1 every cycle and `WriteData`=0x10,0x11,…
  - `CoreReset`=0 for edges t+3..t+7 exactly.
  - `Done`=1 at t+8.
  - `Count`=5.
  - Drained order is 0x10..0x14.
- Overflow: `DEPTH`=16, `RunCycles`=20, `WriteValid`=1 always, `TraceReady`=0.
  - `Count`=16 and `Overflow`=1.
  - Drained data are the first 16 values only.
- Full with concurrent pop: FIFO full, `TraceReady`=1 during RUN with `WriteValid`=1. Required: `Count` stays 16, `Overflow` stays 0, and order is preserved across pointer wrap.
- Start handling:
  - `Start` pulsed during RUN is ignored: run length and `Done` timing are unchanged.
  - `Start` in DONE clears `Count` and `Overflow` and begins HOLD at the next edge.
- Reset mid-RUN: drive `Reset`=0 at run cycle 3. Required: next edge gives IDLE, `CoreReset`=1, `Count`=0; `RunCycles`=0 then runs exactly 1 cycle.
